// File: rtl/rxpyhdr_decode_if.sv
// rxpyhdr_decode_if
// Bundles the RX bit-stream handshake from the FEC decoder together with the
// decoded payload-header results returned by rxpyhdr_decode.
//   master : FEC-decoder side; drives the header pulse, type, bit stream, abort
//            and observes the decode results.
//   slave  : rxpyhdr_decode side.
// Signals:
//   rx_hdr_valid  1-cycle pulse, packet header accepted, rx_pk_type valid
//   rx_pk_type    received TYPE field
//   rx_bit_valid  qualifies rx_bit
//   rx_bit        decoded payload bit, LSB first
//   rx_abort      abandons the current packet
//   rx_llid/rx_flow/rx_pylen   captured payload-header fields
//   rx_pylenbit   expected body bits, rx_bitcnt body bits received so far
//   rx_busy, rx_pydone, rx_lenerr, rx_multislot  status
interface rxpyhdr_decode_if;
  logic        rx_hdr_valid;
  logic [3:0]  rx_pk_type;
  logic        rx_bit_valid;
  logic        rx_bit;
  logic        rx_abort;
  logic [1:0]  rx_llid;
  logic        rx_flow;
  logic [9:0]  rx_pylen;
  logic [12:0] rx_pylenbit;
  logic [12:0] rx_bitcnt;
  logic        rx_busy;
  logic        rx_pydone;
  logic        rx_lenerr;
  logic        rx_multislot;

  modport master (
    output rx_hdr_valid, rx_pk_type, rx_bit_valid, rx_bit, rx_abort,
    input  rx_llid, rx_flow, rx_pylen, rx_pylenbit, rx_bitcnt,
           rx_busy, rx_pydone, rx_lenerr, rx_multislot
  );

  modport slave (
    input  rx_hdr_valid, rx_pk_type, rx_bit_valid, rx_bit, rx_abort,
    output rx_llid, rx_flow, rx_pylen, rx_pylenbit, rx_bitcnt,
           rx_busy, rx_pydone, rx_lenerr, rx_multislot
  );
endinterface

// File: rtl/rxpyhdr_decode.sv
// rxpyhdr_decode
// Receive-side packet-type / payload-header decoder. Classifies the received
// TYPE field, parses the in-band payload header (LLID, FLOW, LENGTH) from the
// FEC-decoded bit stream, counts payload body bits and flags end-of-payload
// and over-long LENGTH values. Sits between the RX FEC decoder and the RX
// payload buffer / CRC checker.
// Ports:
//   clk_6M        6 MHz system clock
//   rstz          asynchronous, active-low reset
//   is_BRmode     link in basic-rate mode (0 = EDR)
//   is_eSCO, is_SCO, is_ACL  logical transport of the current link
//   regi_rxpylen  negotiated eSCO payload length in bytes (headerless eSCO)
//   tslot_p       slot-boundary pulse (only used with RXPY_SLOTTRACK_EN)
//   rx            rxpyhdr_decode_if.slave: bit stream in, decode results out
// Configuration macro:
//   RXPY_SLOTTRACK_EN  when defined, tracks multi-slot occupancy on
//                      rx_multislot; otherwise rx_multislot is tied 0.
module rxpyhdr_decode (
  input  logic            clk_6M,
  input  logic            rstz,
  input  logic            is_BRmode,
  input  logic            is_eSCO,
  input  logic            is_SCO,
  input  logic            is_ACL,
  input  logic [9:0]      regi_rxpylen,
  input  logic            tslot_p,
  rxpyhdr_decode_if.slave rx
);

  typedef enum logic [2:0] {S_IDLE, S_VOICE, S_HDR, S_BODY, S_DONE} state_e;
  typedef enum logic [1:0] {K_NONE, K_FIXED, K_HDR, K_VOICE} kind_e;

  typedef struct packed {
    kind_e       kind;
    logic        hdr16;
    logic [9:0]  max_len;
    logic [12:0] fixed_bits;
  } dec_t;

  localparam logic [6:0] VOICE_LAST = 7'd79;

  // Maps TYPE plus link transport/mode to the payload layout. SCO and eSCO
  // links can still carry ACL-style packets, so only their own voice type
  // codes are intercepted before the ACL table.
  function automatic dec_t decode_type(input logic [3:0] t, input logic br,
                                       input logic sco, input logic esco,
                                       input logic acl, input logic [9:0] esco_len);
    dec_t d;
    d.kind       = K_NONE;
    d.hdr16      = 1'b0;
    d.max_len    = 10'd0;
    d.fixed_bits = 13'd0;
    if (t == 4'd2) begin
      d.kind       = K_FIXED;
      d.fixed_bits = 13'd144;
    end else if (sco && (t == 4'd5 || t == 4'd6 || t == 4'd7 || t == 4'd8)) begin
      case (t)
        4'd5:    begin d.kind = K_FIXED; d.fixed_bits = 13'd80;  end
        4'd6:    begin d.kind = K_FIXED; d.fixed_bits = 13'd160; end
        4'd7:    begin d.kind = K_FIXED; d.fixed_bits = 13'd240; end
        default: begin d.kind = K_VOICE; d.max_len = 10'd9;      end
      endcase
    end else if (esco && (t == 4'd6 || t == 4'd7 || t == 4'd12 || t == 4'd13)) begin
      d.kind       = K_FIXED;
      d.fixed_bits = {esco_len, 3'b000};
    end else if (acl) begin
      case (t)
        4'd3:  begin d.kind = K_HDR; d.max_len = 10'd17; end
        4'd4:  begin
          d.kind    = K_HDR;
          d.hdr16   = !br;
          d.max_len = br ? 10'd27 : 10'd54;
        end
        4'd8:  if (!br) begin d.kind = K_HDR; d.hdr16 = 1'b1; d.max_len = 10'd83; end
        4'd9:  if (br)  begin d.kind = K_HDR; d.max_len = 10'd29; end
        4'd10: begin d.kind = K_HDR; d.hdr16 = 1'b1; d.max_len = br ? 10'd121 : 10'd367;  end
        4'd11: begin d.kind = K_HDR; d.hdr16 = 1'b1; d.max_len = br ? 10'd183 : 10'd552;  end
        4'd14: begin d.kind = K_HDR; d.hdr16 = 1'b1; d.max_len = br ? 10'd224 : 10'd679;  end
        4'd15: begin d.kind = K_HDR; d.hdr16 = 1'b1; d.max_len = br ? 10'd339 : 10'd1021; end
        default: ;
      endcase
    end
    // A zero-length headerless payload would never reach its last bit.
    if (d.kind == K_FIXED && d.fixed_bits == 13'd0) d.kind = K_NONE;
    return d;
  endfunction

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [15:0] hdr_q, hdr_d;
  logic        hdr16_q, hdr16_d;
  logic [9:0]  max_len_q, max_len_d;
  logic [1:0]  llid_q, llid_d;
  logic        flow_q, flow_d;
  logic [9:0]  pylen_q, pylen_d;
  logic [12:0] pylenbit_q, pylenbit_d;
  logic [12:0] bitcnt_q, bitcnt_d;
  logic        lenerr_q, lenerr_d;
  logic        pydone_q, pydone_d;

  dec_t        dec;
  logic [15:0] hdr_shift;
  logic [9:0]  hdr_len;
  logic [1:0]  hdr_llid;
  logic        hdr_flow;
  logic [6:0]  hdr_last;

  assign dec = decode_type(rx.rx_pk_type, is_BRmode, is_SCO, is_eSCO, is_ACL, regi_rxpylen);

  // Header bits arrive LSB first and are shifted in from the top, so an
  // 8-bit header ends up in the upper byte and a 16-bit header fills it all.
  assign hdr_shift = {rx.rx_bit, hdr_q[15:1]};
  assign hdr_len   = hdr16_q ? hdr_shift[12:3] : {5'd0, hdr_shift[15:11]};
  assign hdr_llid  = hdr16_q ? hdr_shift[1:0]  : hdr_shift[9:8];
  assign hdr_flow  = hdr16_q ? hdr_shift[2]    : hdr_shift[10];
  assign hdr_last  = hdr16_q ? 7'd15 : 7'd7;

  // Next-state and datapath: abort wins over a new header, which wins over
  // ordinary bit processing; the bit in the header-valid cycle is dropped.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    hdr16_d    = hdr16_q;
    max_len_d  = max_len_q;
    llid_d     = llid_q;
    flow_d     = flow_q;
    pylen_d    = pylen_q;
    pylenbit_d = pylenbit_q;
    bitcnt_d   = bitcnt_q;
    lenerr_d   = lenerr_q;
    pydone_d   = 1'b0;
    if (rx.rx_abort) begin
      state_d = S_IDLE;
    end else if (rx.rx_hdr_valid) begin
      cnt_d      = 7'd0;
      hdr_d      = 16'd0;
      hdr16_d    = dec.hdr16;
      max_len_d  = dec.max_len;
      llid_d     = 2'd0;
      flow_d     = 1'b0;
      pylen_d    = 10'd0;
      pylenbit_d = dec.fixed_bits;
      bitcnt_d   = 13'd0;
      lenerr_d   = 1'b0;
      case (dec.kind)
        K_FIXED: state_d = S_BODY;
        K_HDR:   state_d = S_HDR;
        K_VOICE: state_d = S_VOICE;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_VOICE: if (rx.rx_bit_valid) begin
          if (cnt_q == VOICE_LAST) begin
            cnt_d   = 7'd0;
            state_d = S_HDR;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
        S_HDR: if (rx.rx_bit_valid) begin
          hdr_d = hdr_shift;
          if (cnt_q == hdr_last) begin
            llid_d     = hdr_llid;
            flow_d     = hdr_flow;
            pylen_d    = hdr_len;
            pylenbit_d = {hdr_len, 3'b000};
            if (hdr_len == 10'd0) begin
              state_d = S_DONE;
            end else if (hdr_len > max_len_q) begin
              lenerr_d = 1'b1;
              state_d  = S_DONE;
            end else begin
              state_d = S_BODY;
            end
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
        // The final body bit is not added to bitcnt, so it ends at pylenbit-1.
        S_BODY: if (rx.rx_bit_valid) begin
          if (bitcnt_q == pylenbit_q - 13'd1) begin
            state_d  = S_DONE;
            pydone_d = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + 13'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q    <= S_IDLE;
      cnt_q      <= 7'd0;
      hdr_q      <= 16'd0;
      hdr16_q    <= 1'b0;
      max_len_q  <= 10'd0;
      llid_q     <= 2'd0;
      flow_q     <= 1'b0;
      pylen_q    <= 10'd0;
      pylenbit_q <= 13'd0;
      bitcnt_q   <= 13'd0;
      lenerr_q   <= 1'b0;
      pydone_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      hdr16_q    <= hdr16_d;
      max_len_q  <= max_len_d;
      llid_q     <= llid_d;
      flow_q     <= flow_d;
      pylen_q    <= pylen_d;
      pylenbit_q <= pylenbit_d;
      bitcnt_q   <= bitcnt_d;
      lenerr_q   <= lenerr_d;
      pydone_q   <= pydone_d;
    end
  end

  assign rx.rx_llid     = llid_q;
  assign rx.rx_flow     = flow_q;
  assign rx.rx_pylen    = pylen_q;
  assign rx.rx_pylenbit = pylenbit_q;
  assign rx.rx_bitcnt   = bitcnt_q;
  assign rx.rx_busy     = (state_q != S_IDLE);
  assign rx.rx_pydone   = pydone_q;
  assign rx.rx_lenerr   = lenerr_q;

`ifdef RXPY_SLOTTRACK_EN
  logic [2:0] slot_cnt_q, slot_cnt_d;
  logic       multislot_q, multislot_d;

  // slot_cnt holds the continuation slots still to come; each slot pulse
  // that finds one pending keeps the receiver marked as occupied.
  always_comb begin
    slot_cnt_d  = slot_cnt_q;
    multislot_d = multislot_q;
    if (rx.rx_abort) begin
      slot_cnt_d  = 3'd0;
      multislot_d = 1'b0;
    end else if (rx.rx_hdr_valid) begin
      multislot_d = 1'b0;
      case (rx.rx_pk_type)
        4'd10, 4'd11, 4'd12, 4'd13: slot_cnt_d = 3'd2;
        4'd14, 4'd15:               slot_cnt_d = 3'd4;
        default:                    slot_cnt_d = 3'd0;
      endcase
    end else if (tslot_p) begin
      if (slot_cnt_q != 3'd0) begin
        multislot_d = 1'b1;
        slot_cnt_d  = slot_cnt_q - 3'd1;
      end else begin
        multislot_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      slot_cnt_q  <= 3'd0;
      multislot_q <= 1'b0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      multislot_q <= multislot_d;
    end
  end

  assign rx.rx_multislot = multislot_q;
`else
  logic unused_tslot;
  assign unused_tslot    = tslot_p;
  assign rx.rx_multislot = 1'b0;
`endif

endmodule

// File: tb/tb_rxpyhdr_decode.sv
// tb_rxpyhdr_decode
// Drives packets into rxpyhdr_decode and checks the decode results through a
// scoreboard: each packet pushes its expected outcome when it is sent, and
// the monitor pops and compares it when the decoder returns to idle.
module tb_rxpyhdr_decode;

  logic       clk_6M = 1'b0;
  logic       rstz;
  logic       is_BRmode, is_eSCO, is_SCO, is_ACL;
  logic [9:0] regi_rxpylen;
  logic       tslot_p;

  rxpyhdr_decode_if bus();

  rxpyhdr_decode dut (
    .clk_6M       (clk_6M),
    .rstz         (rstz),
    .is_BRmode    (is_BRmode),
    .is_eSCO      (is_eSCO),
    .is_SCO       (is_SCO),
    .is_ACL       (is_ACL),
    .regi_rxpylen (regi_rxpylen),
    .tslot_p      (tslot_p),
    .rx           (bus)
  );

  always #5 clk_6M = ~clk_6M;

  typedef struct {
    string      tag;
    logic [3:0] ptype;
    bit         br, sco, esco, acl;
    logic [9:0] escoLen;
    int         voiceBits, hdrBits, bodyBits;
    logic [1:0] llid;
    bit         flow;
    logic [9:0] len;
    bit         gaps;
    int         abortAt;
    bit         push;
    int         expPydone, expN, expPylenbit, expBitcnt;
    int         expPylen, expLlid, expFlow, expLenerr;
  } pkt_t;

  pkt_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   bitCount = 0;
  int   pydoneCount = 0;
  int   pydoneAt = -1;
  bit   prevBusy = 1'b0;
  bit   slotEn;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    total++;
    if (got !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, expected);
    end
  endtask

  function automatic pkt_t mk(input string tag, input logic [3:0] t, input bit br, input bit sco,
                              input bit esco, input bit acl, input int voiceBits, input int hdrBits,
                              input logic [1:0] llid, input bit flow, input logic [9:0] len,
                              input int bodyBits);
    pkt_t p;
    p.tag = tag; p.ptype = t; p.br = br; p.sco = sco; p.esco = esco; p.acl = acl;
    p.escoLen = 10'd0; p.voiceBits = voiceBits; p.hdrBits = hdrBits; p.bodyBits = bodyBits;
    p.llid = llid; p.flow = flow; p.len = len; p.gaps = 1'b0; p.abortAt = -1; p.push = 1'b1;
    p.expPydone = 0; p.expN = 0; p.expPylenbit = 0; p.expBitcnt = 0; p.expLenerr = 0;
    p.expPylen = (hdrBits > 0) ? int'(len)  : -1;
    p.expLlid  = (hdrBits > 0) ? int'(llid) : -1;
    p.expFlow  = (hdrBits > 0) ? int'(flow) : -1;
    return p;
  endfunction

  function automatic pkt_t withExp(input pkt_t p, input int pydone, input int n,
                                   input int pylenbit, input int bitcnt, input int lenerr);
    pkt_t q;
    q = p;
    q.expPydone = pydone; q.expN = n; q.expPylenbit = pylenbit;
    q.expBitcnt = bitcnt; q.expLenerr = lenerr;
    return q;
  endfunction

  task automatic tick(input bit v, input bit b);
    @(negedge clk_6M);
    bus.rx_hdr_valid = 1'b0;
    bus.rx_abort     = 1'b0;
    tslot_p          = 1'b0;
    bus.rx_bit_valid = v;
    bus.rx_bit       = b;
    @(posedge clk_6M);
    #1;
  endtask

  task automatic startPacket(input logic [3:0] t, input bit br, input bit sco, input bit esco,
                             input bit acl, input logic [9:0] escoLen);
    @(negedge clk_6M);
    is_BRmode        = br;
    is_SCO           = sco;
    is_eSCO          = esco;
    is_ACL           = acl;
    regi_rxpylen     = escoLen;
    bus.rx_pk_type   = t;
    bus.rx_hdr_valid = 1'b1;
    bus.rx_abort     = 1'b0;
    tslot_p          = 1'b0;
    bus.rx_bit_valid = 1'b1;
    bus.rx_bit       = 1'b1;
    @(posedge clk_6M);
    #1;
  endtask

  task automatic pulseSlot();
    @(negedge clk_6M);
    bus.rx_hdr_valid = 1'b0;
    bus.rx_bit_valid = 1'b0;
    tslot_p          = 1'b1;
    @(posedge clk_6M);
    #1;
  endtask

  task automatic applyStimulus(input pkt_t p);
    int         sent;
    int         totalBits;
    logic [15:0] h;
    bit         b;
    if (p.push) expQ.push_back(p);
    startPacket(p.ptype, p.br, p.sco, p.esco, p.acl, p.escoLen);
    h = (p.hdrBits == 16) ? {3'b000, p.len, p.flow, p.llid} : {8'd0, p.len[4:0], p.flow, p.llid};
    totalBits = p.voiceBits + p.hdrBits + p.bodyBits;
    sent = 0;
    for (int i = 0; i < totalBits; i++) begin
      if (sent == p.abortAt) break;
      if (p.gaps && (i % 3 == 2)) tick(1'b0, 1'b0);
      if (i >= p.voiceBits && i < p.voiceBits + p.hdrBits) b = h[i - p.voiceBits];
      else b = 1'($urandom);
      tick(1'b1, b);
      sent++;
    end
    if (p.abortAt >= 0 && sent == p.abortAt) begin
      @(negedge clk_6M);
      bus.rx_abort     = 1'b1;
      bus.rx_bit_valid = 1'b1;
      bus.rx_bit       = 1'b1;
      @(posedge clk_6M);
      #1;
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic waitDone(input string tag);
    for (int k = 0; k < 200 && expQ.size() != 0; k++) @(negedge clk_6M);
    if (expQ.size() != 0) begin
      checkOutput({tag, ".pending"}, expQ.size(), 0);
      expQ.delete();
    end
  endtask

  // Monitor: counts the valid bits the bench itself drove since the last
  // header pulse, notes when rx_pydone fires, and scores a packet when the
  // decoder drops back to idle.
  always @(posedge clk_6M) begin
    pkt_t e;
    if (bus.rx_hdr_valid && !bus.rx_abort) begin
      bitCount    = 0;
      pydoneCount = 0;
      pydoneAt    = -1;
    end else if (bus.rx_bit_valid) begin
      bitCount++;
    end
    #1;
    if (bus.rx_pydone === 1'b1) begin
      pydoneCount++;
      pydoneAt = bitCount;
    end
    if (prevBusy && bus.rx_busy === 1'b0) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_end", 32'(expQ.size()), 1);
      end else begin
        e = expQ.pop_front();
        checkOutput({e.tag, ".pydone_cnt"}, pydoneCount, e.expPydone);
        if (e.expPydone != 0) checkOutput({e.tag, ".pydone_at"}, pydoneAt, e.expN);
        checkOutput({e.tag, ".pylenbit"}, 32'(bus.rx_pylenbit), e.expPylenbit);
        checkOutput({e.tag, ".bitcnt"}, 32'(bus.rx_bitcnt), e.expBitcnt);
        checkOutput({e.tag, ".lenerr"}, 32'(bus.rx_lenerr), e.expLenerr);
        if (e.expPylen >= 0) checkOutput({e.tag, ".pylen"}, 32'(bus.rx_pylen), e.expPylen);
        if (e.expLlid >= 0)  checkOutput({e.tag, ".llid"}, 32'(bus.rx_llid), e.expLlid);
        if (e.expFlow >= 0)  checkOutput({e.tag, ".flow"}, 32'(bus.rx_flow), e.expFlow);
      end
      pydoneCount = 0;
      pydoneAt    = -1;
    end
    prevBusy = (bus.rx_busy === 1'b1);
  end

  initial begin
    pkt_t p;
`ifdef RXPY_SLOTTRACK_EN
    slotEn = 1'b1;
`else
    slotEn = 1'b0;
`endif
    rstz = 1'b0;
    is_BRmode = 1'b1; is_eSCO = 1'b0; is_SCO = 1'b0; is_ACL = 1'b1;
    regi_rxpylen = 10'd0; tslot_p = 1'b0;
    bus.rx_hdr_valid = 1'b0; bus.rx_pk_type = 4'd0; bus.rx_bit_valid = 1'b0;
    bus.rx_bit = 1'b0; bus.rx_abort = 1'b0;

    repeat (3) @(negedge clk_6M);
    checkOutput("reset.busy", 32'(bus.rx_busy), 0);
    checkOutput("reset.pydone", 32'(bus.rx_pydone), 0);
    checkOutput("reset.pylenbit", 32'(bus.rx_pylenbit), 0);
    checkOutput("reset.bitcnt", 32'(bus.rx_bitcnt), 0);
    checkOutput("reset.lenerr", 32'(bus.rx_lenerr), 0);
    checkOutput("reset.pylen", 32'(bus.rx_pylen), 0);
    checkOutput("reset.multislot", 32'(bus.rx_multislot), 0);
    rstz = 1'b1;
    tick(1'b0, 1'b0);

    // NULL carries no payload: the decoder must stay idle.
    startPacket(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0);
    tick(1'b0, 1'b0);
    checkOutput("null.busy", 32'(bus.rx_busy), 0);

    p = withExp(mk("dm1", 4'd3, 1, 0, 0, 1, 0, 8, 2'd2, 1'b1, 10'd10, 96), 1, 88, 80, 79, 0);
    applyStimulus(p); waitDone("dm1");

    p = withExp(mk("dh1_lenerr", 4'd4, 1, 0, 0, 1, 0, 8, 2'd1, 1'b0, 10'd28, 16), 0, 0, 224, 0, 1);
    applyStimulus(p); waitDone("dh1_lenerr");

    p = withExp(mk("2dh1_lenerr", 4'd4, 0, 0, 0, 1, 0, 16, 2'd3, 1'b1, 10'd55, 8), 0, 0, 440, 0, 1);
    applyStimulus(p); waitDone("2dh1_lenerr");

    p = withExp(mk("dm1_len0", 4'd3, 1, 0, 0, 1, 0, 8, 2'd1, 1'b1, 10'd0, 8), 0, 0, 0, 0, 0);
    applyStimulus(p); waitDone("dm1_len0");

    p = withExp(mk("dh3_max", 4'd11, 1, 0, 0, 1, 0, 16, 2'd3, 1'b1, 10'd183, 1464), 1, 1480, 1464, 1463, 0);
    applyStimulus(p); waitDone("dh3_max");

    p = withExp(mk("3dh5", 4'd15, 0, 0, 0, 1, 0, 16, 2'd2, 1'b0, 10'd1021, 8168), 1, 8184, 8168, 8167, 0);
    p.gaps = 1'b1;
    applyStimulus(p); waitDone("3dh5");

    p = withExp(mk("dv", 4'd8, 1, 1, 0, 0, 80, 8, 2'd1, 1'b1, 10'd9, 72), 1, 160, 72, 71, 0);
    applyStimulus(p); waitDone("dv");

    p = withExp(mk("hv3", 4'd7, 1, 1, 0, 0, 0, 0, 2'd0, 1'b0, 10'd0, 240), 1, 240, 240, 239, 0);
    applyStimulus(p); waitDone("hv3");

    p = withExp(mk("hv3_abort", 4'd7, 1, 1, 0, 0, 0, 0, 2'd0, 1'b0, 10'd0, 240), 0, 0, 240, 99, 0);
    p.abortAt = 99;
    applyStimulus(p); waitDone("hv3_abort");

    p = withExp(mk("ev3", 4'd7, 1, 0, 1, 0, 0, 0, 2'd0, 1'b0, 10'd0, 240), 1, 240, 240, 239, 0);
    p.escoLen = 10'd30;
    applyStimulus(p); waitDone("ev3");

    p = withExp(mk("fhs", 4'd2, 1, 0, 0, 1, 0, 0, 2'd0, 1'b0, 10'd0, 144), 1, 144, 144, 143, 0);
    applyStimulus(p); waitDone("fhs");

    // DM5 with slot pulses, then restarted mid-packet by a second DM5 and a DM1.
    p = mk("dm5_part", 4'd14, 1, 0, 0, 1, 0, 16, 2'd1, 1'b0, 10'd200, 40);
    p.push = 1'b0;
    startPacket(p.ptype, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0);
    for (int i = 0; i < 16; i++) tick(1'b1, (i >= 3 && i < 13) ? p.len[i-3] : 1'b0);
    checkOutput("dm5.multislot_pre", 32'(bus.rx_multislot), 0);
    for (int k = 1; k <= 5; k++) begin
      repeat (3) tick(1'b1, 1'($urandom));
      pulseSlot();
      checkOutput($sformatf("dm5.multislot_%0d", k), 32'(bus.rx_multislot), 32'(slotEn && k <= 4));
    end
    startPacket(4'd14, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0);
    tick(1'b1, 1'b0);
    pulseSlot();
    checkOutput("dm5b.multislot_1", 32'(bus.rx_multislot), 32'(slotEn));
    p = withExp(mk("restart_dm1", 4'd3, 1, 0, 0, 1, 0, 8, 2'd1, 1'b0, 10'd5, 40), 1, 48, 40, 39, 0);
    applyStimulus(p); waitDone("restart_dm1");
    checkOutput("restart.multislot", 32'(bus.rx_multislot), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
